// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_meter_pkg
// Purpose  : Shared types and default constants for the pulse period meter.
//            The divider period/high constants live here as well, so the
//            loop-back self-test reads the values it expects from the same
//            place the clock divider is configured from.
// Contents : state_t         - measurement FSM states
//            PM_CNT_W        - default counter / output width
//            PM_TIMEOUT      - default largest accepted period (cycles)
//            DIV_PERIOD/HIGH - loop-back divider waveform (cycles)
// Revision : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

   typedef enum logic [0:0] {
      ARM = 1'b0,   // waiting for the first rising edge
      RUN = 1'b1    // measuring between consecutive rising edges
   } state_t;

   localparam int PM_CNT_W   = 32;
   localparam int PM_TIMEOUT = 2500;

   localparam int DIV_PERIOD = 1251;
   localparam int DIV_HIGH   = 626;
   localparam int DIV_LOW    = DIV_PERIOD - DIV_HIGH;

endpackage : pulse_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Brings an asynchronous input into the clock domain through a
//            flop chain and flags its rising and falling edges.
// Ports    : clock   - system clock
//            reset   - asynchronous, active-high reset (chain clears to 0)
//            i_async - asynchronous input
//            o_level - synchronised level
//            o_rise  - one-cycle pulse on a synchronised 0->1 transition
//            o_fall  - one-cycle pulse on a synchronised 1->0 transition
// Params   : SYNC_STAGES - synchroniser depth, must be at least 2
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level_d;
   logic                   w_level;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync    <= '0;
         r_level_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_level_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_level = r_sync[SYNC_STAGES-1];
   assign o_level = w_level;
   assign o_rise  = w_level & ~r_level_d;
   assign o_fall  = ~w_level & r_level_d;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_period_meter
// Purpose  : Measures a periodic pulse train in system-clock cycles. Reports
//            the period between the last two rising edges and the high time
//            within it, with a one-cycle valid strobe plus lock and
//            loss-of-signal status.
// Ports    : clock      - system clock
//            reset      - asynchronous, active-high reset
//            pulse_in   - asynchronous pulse train
//            period     - cycles between the last two rising edges
//            high_time  - cycles high within the last measured period
//            meas_valid - one-cycle strobe, period/high_time updated
//            locked     - a valid measurement since reset or timeout
//            timeout    - loss of signal, cleared by the next measurement
// Params   : CNT_W       - counter and output width
//            SYNC_STAGES - synchroniser depth (>= 2)
//            TIMEOUT     - largest accepted period, < 2^CNT_W - 1
// Revision : 1.0 - initial release
// ============================================================================
module pulse_period_meter
   import pulse_meter_pkg::*;
#(
   parameter int CNT_W       = PM_CNT_W,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = PM_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

   // Only the edges carry timing information; the level is not needed here.
   logic w_level_unused;
   logic w_rise;
   logic w_fall;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .i_async (pulse_in),
      .o_level (w_level_unused),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hi_lat;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high_time;
   logic             r_valid;
   logic             r_locked;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_hi_lat_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic [CNT_W-1:0] w_high_time_nxt;
   logic             w_valid_nxt;
   logic             w_locked_nxt;
   logic             w_timeout_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ARM;
         r_cnt       <= '0;
         r_hi_lat    <= '0;
         r_period    <= '0;
         r_high_time <= '0;
         r_valid     <= 1'b0;
         r_locked    <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hi_lat    <= w_hi_lat_nxt;
         r_period    <= w_period_nxt;
         r_high_time <= w_high_time_nxt;
         r_valid     <= w_valid_nxt;
         r_locked    <= w_locked_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // The counter is 1 in the cycle after a rise, so at the next falling edge
   // it equals the high time and at the next rise it equals the period.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_hi_lat_nxt    = r_hi_lat;
      w_period_nxt    = r_period;
      w_high_time_nxt = r_high_time;
      w_valid_nxt     = 1'b0;
      w_locked_nxt    = r_locked;
      w_timeout_nxt   = r_timeout;

      case (r_state)
         ARM: begin
            // First edge only establishes a reference; nothing to report.
            if (w_rise) begin
               w_cnt_nxt   = C_ONE;
               w_state_nxt = RUN;
            end
         end

         RUN: begin
            if (w_rise) begin
               // A rise landing on the TIMEOUT count is still accepted.
               w_period_nxt    = r_cnt;
               w_high_time_nxt = r_hi_lat;
               w_valid_nxt     = 1'b1;
               w_locked_nxt    = 1'b1;
               w_timeout_nxt   = 1'b0;
               w_cnt_nxt       = C_ONE;
            end else if (r_cnt == C_TIMEOUT) begin
               // Cleared so the counter can never climb past TIMEOUT.
               w_timeout_nxt = 1'b1;
               w_locked_nxt  = 1'b0;
               w_cnt_nxt     = '0;
               w_state_nxt   = ARM;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
               if (w_fall) begin
                  w_hi_lat_nxt = r_cnt;
               end
            end
         end

         default: begin
            w_state_nxt = ARM;
         end
      endcase
   end

   assign period     = r_period;
   assign high_time  = r_high_time;
   assign meas_valid = r_valid;
   assign locked     = r_locked;
   assign timeout    = r_timeout;

endmodule : pulse_period_meter
`default_nettype wire
